fsm: RTL and testbench

Serial sequence detector that watches a 1-bit input stream and flags every occurrence of the pattern 1-0-1, with overlaps allowed. It is a 4-state Moore machine clocked once per input bit. It sits at the bit-serial front end of the design: upstream logic presents one bit per clock on `inp`, and downstream logic consumes the registered match flag `outp`.

---
 rtl/fsm.sv | 43 ++++
 tb/tb_fsm.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fsm.sv
// Serial 1-0-1 sequence detector, overlapping matches allowed.
// Four-state Moore machine; the match flag is decoded from state only.
module fsm (
    input  logic clk,
    input  logic rst,
    input  logic inp,
    output logic outp
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // State register; a low rst forces idle without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; from S3 a 0 reuses the trailing "10" so overlaps count.
    always_comb begin
        state_nxt = S0;
        case (state)
            S0:      state_nxt = inp ? S1 : S0;
            S1:      state_nxt = inp ? S1 : S2;
            S2:      state_nxt = inp ? S3 : S0;
            S3:      state_nxt = inp ? S1 : S2;
            default: state_nxt = S0;
        endcase
    end

    assign outp = (state == S3);

endmodule

// File: tb/tb_fsm.sv
// Bench for the 1-0-1 detector: history model checked every cycle,
// plus directed vectors with literal expected states.
module tb_fsm;

    logic clk;
    logic rst;
    logic inp;
    logic outp;

    int tests;
    int fails;

    logic [2:0] hist;

    fsm dut (
        .clk  (clk),
        .rst  (rst),
        .inp  (inp),
        .outp (outp)
    );

    // Expected state from the last three bits seen since reset:
    // longest suffix of the history that is a prefix of "101".
    function automatic logic [1:0] model_state(input logic [2:0] h);
        if (h == 3'b101)
            return 2'd3;
        else if (h[1:0] == 2'b10)
            return 2'd2;
        else if (h[0])
            return 2'd1;
        else
            return 2'd0;
    endfunction

    task automatic chk(input string nm, input logic [1:0] act,
                       input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Bit history since reset; zeros after reset can never fake a match.
    always @(posedge clk or negedge rst) begin
        if (!rst)
            hist <= 3'b000;
        else
            hist <= {hist[1:0], inp};
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("model_state", dut.state, model_state(hist));
        chk("model_outp", {1'b0, outp},
            {1'b0, (model_state(hist) == 2'd3)});
    end

    task automatic step(input logic b, input logic [1:0] es,
                        input string nm);
        inp = b;
        #5 clk = 1'b1;
        #5 clk = 1'b0;
        #1;
        chk({nm, "_state"}, dut.state, es);
        chk({nm, "_outp"}, {1'b0, outp}, {1'b0, (es == 2'd3)});
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_state", dut.state, 2'd0);
        chk("rst_outp", {1'b0, outp}, 2'd0);
        #2 rst = 1'b1;
        #2;
    endtask

    logic [15:0] word;
    logic [1:0]  st_tab [16];

    initial begin
        tests = 0;
        fails = 0;
        clk = 1'b0;
        inp = 1'b0;
        rst = 1'b0;

        #5;
        chk("por_state", dut.state, 2'd0);
        chk("por_outp", {1'b0, outp}, 2'd0);
        rst = 1'b1;
        #5;

        word = 16'b0101_0111_0111_0010;
        st_tab = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                   2'd3, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
        for (int i = 0; i < 16; i++)
            step(word[i], st_tab[i], $sformatf("stream%0d", i + 1));

        do_reset();
        step(1'b1, 2'd1, "ovl1");
        step(1'b0, 2'd2, "ovl2");
        step(1'b1, 2'd3, "ovl3");
        step(1'b0, 2'd2, "ovl4");
        step(1'b1, 2'd3, "ovl5");

        do_reset();
        step(1'b1, 2'd1, "nm1");
        step(1'b1, 2'd1, "nm2");
        step(1'b0, 2'd2, "nm3");
        step(1'b0, 2'd0, "nm4");
        step(1'b1, 2'd1, "nm5");

        do_reset();
        step(1'b1, 2'd1, "mid1");
        step(1'b0, 2'd2, "mid2");
        do_reset();
        step(1'b1, 2'd1, "mid_after");
        step(1'b0, 2'd2, "mid_after2");
        step(1'b1, 2'd3, "mid_after3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
